// File: rtl/gptp_pkg.sv
// gptp_pkg: frame-type codes, messageType nibbles and frame field positions shared by gPTP encoder/decoder
package gptp_pkg;
  localparam int FRAME_W = 432;
  localparam int MT_LSB = 80;
  localparam int SEQ_LSB = 84;
  localparam int TS_LSB = 352;
  localparam int TS_FIELD_W = 80;
  localparam logic [7:0] TYPE_SYNC = 8'h01;
  localparam logic [7:0] TYPE_FU = 8'h02;
  localparam logic [7:0] TYPE_PREQ = 8'h04;
  localparam logic [7:0] TYPE_PRESP = 8'h88;
  localparam logic [7:0] TYPE_PFU = 8'h10;
  localparam logic [3:0] MT_SYNC = 4'h0;
  localparam logic [3:0] MT_PREQ = 4'h2;
  localparam logic [3:0] MT_PRESP = 4'h3;
  localparam logic [3:0] MT_FU = 4'h8;
  localparam logic [3:0] MT_PFU = 4'hA;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/gptp_tx_frame_build.sv
// gptp_tx_frame_build: maps a send request onto the 432-bit frame image, messageType and type validity
module gptp_tx_frame_build
  import gptp_pkg::*;
#(
  parameter int TS_W = 80
) (
  input  logic [7:0]         req_type,
  input  logic [TS_W-1:0]    req_ts,
  input  logic [15:0]        req_seq_id,
  input  logic [15:0]        sync_seq,
  input  logic [15:0]        preq_seq,
  output logic [FRAME_W-1:0] frame,
  output logic [3:0]         msg_type,
  output logic               valid
);
  logic [15:0] seq;
  logic        carry_ts;
  always_comb begin
    valid = 1'b1;
    msg_type = MT_SYNC;
    seq = sync_seq;
    carry_ts = 1'b0;
    case (req_type)
      TYPE_SYNC: ;
      TYPE_FU: begin
        msg_type = MT_FU;
        seq = sync_seq - 16'd1;
        carry_ts = 1'b1;
      end
      TYPE_PREQ: begin
        msg_type = MT_PREQ;
        seq = preq_seq;
      end
      TYPE_PRESP: begin
        msg_type = MT_PRESP;
        seq = req_seq_id;
        carry_ts = 1'b1;
      end
      TYPE_PFU: begin
        msg_type = MT_PFU;
        seq = req_seq_id;
        carry_ts = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    frame = '0;
    frame[MT_LSB +: 4] = msg_type;
    frame[SEQ_LSB +: 16] = seq;
    frame[TS_LSB +: TS_W] = carry_ts ? req_ts : '0;
  end
endmodule

// File: rtl/gptp_tx_enc_frame.sv
// gptp_tx_enc_frame: builds a gPTP frame image per request and streams it MSB byte first to the MAC.
// Define GPTP_TX_EGRESS_TS_EN to capture local_time at the SOF handshake onto done_ts.
module gptp_tx_enc_frame
  import gptp_pkg::*;
#(
  parameter int FRAME_BYTES = 54,
  parameter int TS_W = 80
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      req_type,
  input  logic [TS_W-1:0] req_ts,
  input  logic [15:0]     req_seq_id,
  input  logic [TS_W-1:0] local_time,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            tx_last,
  input  logic            tx_ready,
  output logic            done_valid,
  output logic [7:0]      done_type,
  output logic [TS_W-1:0] done_ts,
  output logic            err_type
);
  localparam int CW = $clog2(FRAME_BYTES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);
  state_t state, state_n;
  logic [FRAME_W-1:0] frame_b, frame_q;
  logic [3:0] unused_msg_type;
  logic type_ok, accept, hs, last_hs;
  logic [7:0] type_q;
  logic [CW-1:0] cnt;
  logic [15:0] sync_seq, preq_seq;
  gptp_tx_frame_build #(.TS_W(TS_W)) u_build (
    .req_type(req_type),
    .req_ts(req_ts),
    .req_seq_id(req_seq_id),
    .sync_seq(sync_seq),
    .preq_seq(preq_seq),
    .frame(frame_b),
    .msg_type(unused_msg_type),
    .valid(type_ok)
  );
  assign accept = req_valid & req_ready;
  assign tx_valid = (state == SEND);
  assign tx_last = tx_valid && (cnt == LAST);
  assign tx_data = tx_valid ? frame_q[FRAME_W-1 -: 8] : 8'h00;
  assign hs = tx_valid & tx_ready;
  assign last_hs = hs & tx_last;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (accept && type_ok) ? SEND : IDLE;
      SEND: state_n = last_hs ? DONE : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      frame_q <= '0;
      type_q <= '0;
      cnt <= '0;
      sync_seq <= '0;
      preq_seq <= '0;
      done_valid <= 1'b0;
      done_type <= '0;
      err_type <= 1'b0;
    end else begin
      state <= state_n;
      req_ready <= (state_n == IDLE);
      err_type <= accept & ~type_ok;
      done_valid <= last_hs;
      if (accept && type_ok) begin
        frame_q <= frame_b;
        type_q <= req_type;
        cnt <= '0;
      end
      // the image shifts out so the current byte always sits in the top 8 bits
      if (hs) begin
        frame_q <= frame_q << 8;
        cnt <= cnt + CW'(1);
      end
      if (last_hs) begin
        cnt <= '0;
        done_type <= type_q;
        sync_seq <= sync_seq + 16'(type_q == TYPE_SYNC);
        preq_seq <= preq_seq + 16'(type_q == TYPE_PREQ);
      end
    end
  end
`ifdef GPTP_TX_EGRESS_TS_EN
  logic [TS_W-1:0] egress_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      egress_q <= '0;
      done_ts <= '0;
    end else begin
      if (hs && cnt == '0) egress_q <= local_time;
      if (last_hs) done_ts <= egress_q;
    end
  end
`else
  logic unused_local_time;
  assign unused_local_time = ^local_time;
  assign done_ts = '0;
`endif
endmodule

// File: tb/tb_gptp_tx_enc_frame.sv
// tb_gptp_tx_enc_frame: directed self-checking bench for the gPTP transmit frame encoder
module tb_gptp_tx_enc_frame;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] req_type = 8'h00;
  logic [79:0] req_ts = '0;
  logic [15:0] req_seq_id = '0;
  logic [79:0] local_time = '0;
  logic [7:0] tx_data;
  logic tx_valid, tx_last;
  logic tx_ready = 1'b1;
  logic done_valid;
  logic [7:0] done_type;
  logic [79:0] done_ts;
  logic err_type;
  int checks = 0;
  int errors = 0;
  logic [7:0] rx [0:53];
  int nhs, ncyc;
`ifdef GPTP_TX_EGRESS_TS_EN
  localparam logic [79:0] EXP_TS = 80'd500;
`else
  localparam logic [79:0] EXP_TS = 80'd0;
`endif
  gptp_tx_enc_frame dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_ts(req_ts), .req_seq_id(req_seq_id), .local_time(local_time),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .done_valid(done_valid), .done_type(done_type), .done_ts(done_ts), .err_type(err_type)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [79:0] field(input int first, input int n);
    logic [79:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[71:0], rx[first + i]};
    return v;
  endfunction
  task automatic reset_idle_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_last"}, tx_last, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_done_valid"}, done_valid, 0);
    chk({tag, "_err_type"}, err_type, 0);
    chk({tag, "_done_type"}, done_type, 0);
    chk({tag, "_done_ts"}, done_ts, 0);
  endtask
  // abort_at < 0 runs the frame to completion; otherwise reset is asserted when byte abort_at is presented
  task automatic run_frame(input string tag, input logic [7:0] typ, input logic [79:0] ts,
                           input logic [15:0] sid, input bit toggle, input int abort_at);
    int k = 0;
    int cyc = 0;
    int lastbad = 0;
    bit stalled = 0;
    bit sof = 0;
    logic [7:0] prev = '0;
    for (int i = 0; i < 54; i++) rx[i] = 8'hxx;
    @(negedge clk);
    req_valid = 1'b1; req_type = typ; req_ts = ts; req_seq_id = sid; local_time = 80'd500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_busy_ready"}, req_ready, 0);
    chk({tag, "_sof_valid"}, tx_valid, 1);
    while (k < 54 && cyc < 300) begin
      if (sof) local_time = 80'd999;
      tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) chk({tag, "_stall_hold"}, tx_data, prev);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        reset_idle_checks({tag, "_abort"});
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        nhs = k;
        return;
      end
      if (tx_valid && tx_ready) begin
        rx[k] = tx_data;
        if (tx_last !== (k == 53)) lastbad++;
        sof = (k == 0);
        k++;
        stalled = 0;
      end else begin
        sof = 0;
        stalled = tx_valid;
        prev = tx_data;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    nhs = k;
    ncyc = cyc;
    chk({tag, "_handshakes"}, k, 54);
    chk({tag, "_tx_last_pos"}, lastbad, 0);
    chk({tag, "_done_pulse"}, done_valid, 1);
    chk({tag, "_done_type"}, done_type, typ);
    chk({tag, "_done_ts"}, done_ts, EXP_TS);
    chk({tag, "_idle_after"}, tx_valid, 0);
    chk({tag, "_tail_zero"}, field(44, 10), 0);
    @(negedge clk);
    chk({tag, "_done_once"}, done_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
    chk({tag, "_done_type_hold"}, done_type, typ);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_idle_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);
    reset_idle_checks("post_reset");
    run_frame("sync0", 8'h01, 80'hDEAD_BEEF_0123_4567_89AB, 16'h5555, 0, -1);
    chk("sync0_contig", ncyc, 54);
    chk("sync0_ts_zero", field(0, 10), 0);
    chk("sync0_seq_type", field(41, 3), 24'h000000);
    run_frame("fu", 8'h02, 80'h0000_0000_0001_0000_0064, 16'h7777, 0, -1);
    chk("fu_ts", field(0, 10), 80'h0000_0000_0001_0000_0064);
    chk("fu_seq_type", field(41, 3), 24'h000008);
    run_frame("sync1", 8'h01, 80'h0, 16'h0, 0, -1);
    chk("sync1_seq_type", field(41, 3), 24'h000010);
    run_frame("presp", 8'h88, 80'h1122_3344_5566_7788_99AA, 16'h1234, 1, -1);
    chk("presp_cycles", ncyc, 107);
    chk("presp_ts", field(0, 10), 80'h1122_3344_5566_7788_99AA);
    chk("presp_seq_type", field(41, 3), 24'h012343);
    run_frame("pfu", 8'h10, 80'h0A0B_0C0D_0E0F_1011_1213, 16'hABCD, 0, -1);
    chk("pfu_seq_type", field(41, 3), 24'h0ABCDA);
    chk("pfu_ts", field(0, 10), 80'h0A0B_0C0D_0E0F_1011_1213);
    @(negedge clk);
    req_valid = 1'b1; req_type = 8'h03;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bad_err_pulse", err_type, 1);
    chk("bad_no_tx", tx_valid, 0);
    chk("bad_ready", req_ready, 1);
    @(negedge clk);
    chk("bad_err_clear", err_type, 0);
    chk("bad_still_idle", tx_valid, 0);
    chk("bad_no_done", done_valid, 0);
    run_frame("preq_abort", 8'h04, 80'h0, 16'h0, 0, 20);
    chk("preq_abort_bytes", nhs, 20);
    repeat (2) @(negedge clk);
    reset_idle_checks("after_abort");
    run_frame("preq0", 8'h04, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 16'h9999, 0, -1);
    chk("preq0_seq_type", field(41, 3), 24'h000002);
    chk("preq0_ts_zero", field(0, 10), 0);
    run_frame("preq1", 8'h04, 80'h0, 16'h0, 0, -1);
    chk("preq1_seq_type", field(41, 3), 24'h000012);
    run_frame("fu_wrap", 8'h02, 80'h0000_0000_0000_0000_0001, 16'h0, 0, -1);
    chk("fu_wrap_seq_type", field(41, 3), 24'h0FFFF8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
